// File: rtl/adsr_envelope.sv
// ADSR envelope generator: turns a note gate into a 0..127 amplitude contour.
// The envelope steps only on rate-enable ticks. Each phase has its own step interval.
module adsr_envelope #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             gate,
  input  logic [DIV_W-1:0] attack_rate,
  input  logic [DIV_W-1:0] decay_rate,
  input  logic [6:0]       sustain_level,
  input  logic [DIV_W-1:0] release_rate,
  output logic [6:0]       amplitude,
  output logic [2:0]       state,
  output logic             active
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ATTACK  = 3'd1,
    S_DECAY   = 3'd2,
    S_SUSTAIN = 3'd3,
    S_RELEASE = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [6:0]       amp_q, amp_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             gate_q, gate_d;

  logic             rise, fall, step;
  logic [DIV_W-1:0] rate_sel;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      amp_q     <= 7'd0;
      div_cnt_q <= '0;
      gate_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      amp_q     <= amp_d;
      div_cnt_q <= div_cnt_d;
      gate_q    <= gate_d;
    end
  end

  always_comb begin
    rise      = gate & ~gate_q;
    fall      = ~gate & gate_q;
    gate_d    = gate;
    state_d   = state_q;
    amp_d     = amp_q;
    div_cnt_d = div_cnt_q;
    step      = 1'b0;

    unique case (state_q)
      S_ATTACK:  rate_sel = attack_rate;
      S_DECAY:   rate_sel = decay_rate;
      S_RELEASE: rate_sel = release_rate;
      default:   rate_sel = '0;
    endcase

    if (rise) begin
      // Retrigger keeps the current amplitude so the attack resumes from it.
      state_d   = S_ATTACK;
      div_cnt_d = '0;
    end else if (fall && (state_q == S_ATTACK || state_q == S_DECAY ||
                          state_q == S_SUSTAIN)) begin
      state_d   = S_RELEASE;
      div_cnt_d = '0;
    end else if (!fall) begin
      unique case (state_q)
        S_ATTACK, S_DECAY, S_RELEASE: begin
          if (tick) begin
            if (div_cnt_q == rate_sel) begin
              div_cnt_d = '0;
              step      = 1'b1;
            end else begin
              div_cnt_d = div_cnt_q + 1'b1;
            end
          end
        end
        S_SUSTAIN: begin
          div_cnt_d = '0;
          amp_d     = sustain_level;
        end
        default: div_cnt_d = '0;
      endcase

      if (step) begin
        unique case (state_q)
          S_ATTACK: begin
            if (amp_q != 7'd127) amp_d = amp_q + 7'd1;
            if (amp_q >= 7'd126) state_d = S_DECAY;
          end
          S_DECAY: begin
            if (amp_q > sustain_level) begin
              amp_d = amp_q - 7'd1;
              if ((amp_q - 7'd1) <= sustain_level) state_d = S_SUSTAIN;
            end else begin
              state_d = S_SUSTAIN;
            end
          end
          S_RELEASE: begin
            if (amp_q != 7'd0) amp_d = amp_q - 7'd1;
            if (amp_q <= 7'd1) state_d = S_IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  assign amplitude = amp_q;
  assign state     = state_q;
  assign active    = (state_q != S_IDLE);

endmodule

// File: tb/tb_adsr_envelope.sv
// Scoreboard bench for adsr_envelope: expected {active,state,amplitude} words
// are queued with the stimulus and popped once the DUT has produced its output.
module tb_adsr_envelope;

  typedef struct packed {
    logic       act;
    logic [2:0] st;
    logic [6:0] amp;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       gate;
  logic [7:0] attack_rate, decay_rate, release_rate;
  logic [6:0] sustain_level;
  logic [6:0] amplitude;
  logic [2:0] state;
  logic       active;

  obs_t  sb_q[$];
  string tag_q[$];
  obs_t  exp_o, cur_o;
  string tag;
  int    total = 0;
  int    bad = 0;

  always #5 clk = ~clk;

  adsr_envelope #(.DIV_W(8)) dut (
    .clk(clk), .rst(rst), .tick(tick), .gate(gate),
    .attack_rate(attack_rate), .decay_rate(decay_rate),
    .sustain_level(sustain_level), .release_rate(release_rate),
    .amplitude(amplitude), .state(state), .active(active)
  );

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic run_ticks(input int n, input int period);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      step_clk();
      tick = 1'b0;
      for (int j = 1; j < period; j++) step_clk();
    end
  endtask

  task automatic expect_obs(input string name, input logic a, input logic [2:0] s,
                            input logic [6:0] m);
    obs_t e;
    e.act = a; e.st = s; e.amp = m;
    sb_q.push_back(e);
    tag_q.push_back(name);
  endtask

  task automatic test_reset();
    rst = 1'b0; gate = 1'b1; tick = 1'b0;
    attack_rate = 8'd0; decay_rate = 8'd0; release_rate = 8'd0; sustain_level = 7'd64;
    expect_obs("reset_state", 1'b0, 3'd0, 7'd0);
    repeat (3) step_clk();
    cur_o = {active, state, amplitude}; exp_o = sb_q.pop_front(); tag = tag_q.pop_front();
    total++;
    if (cur_o !== exp_o) begin
      bad++;
      $display("FAIL %s: got act=%0b st=%0d amp=%0d want act=%0b st=%0d amp=%0d",
               tag, cur_o.act, cur_o.st, cur_o.amp, exp_o.act, exp_o.st, exp_o.amp);
    end
    rst = 1'b1;
    expect_obs("reset_gate_high", 1'b1, 3'd1, 7'd0);
    step_clk();
    cur_o = {active, state, amplitude}; exp_o = sb_q.pop_front(); tag = tag_q.pop_front();
    total++;
    if (cur_o !== exp_o) begin
      bad++;
      $display("FAIL %s: got act=%0b st=%0d amp=%0d want act=%0b st=%0d amp=%0d",
               tag, cur_o.act, cur_o.st, cur_o.amp, exp_o.act, exp_o.st, exp_o.amp);
    end
  endtask

  task automatic test_attack_decay();
    // {tick count, expected} pairs walked in sequence, tick every clk, rates 0
    int          n_tab[5]   = '{126, 1, 62, 1, 5};
    logic [2:0]  st_tab[5]  = '{3'd1, 3'd2, 3'd2, 3'd3, 3'd3};
    logic [6:0]  amp_tab[5] = '{7'd126, 7'd127, 7'd65, 7'd64, 7'd64};
    string       nm_tab[5]  = '{"attack_126", "attack_top", "decay_65", "decay_sustain", "sustain_hold"};
    for (int k = 0; k < 5; k++) begin
      expect_obs(nm_tab[k], 1'b1, st_tab[k], amp_tab[k]);
      run_ticks(n_tab[k], 1);
      cur_o = {active, state, amplitude}; exp_o = sb_q.pop_front(); tag = tag_q.pop_front();
      total++;
      if (cur_o !== exp_o) begin
        bad++;
        $display("FAIL %s: got act=%0b st=%0d amp=%0d want act=%0b st=%0d amp=%0d",
                 tag, cur_o.act, cur_o.st, cur_o.amp, exp_o.act, exp_o.st, exp_o.amp);
      end
    end
  endtask

  task automatic test_slow_attack();
    rst = 1'b0; gate = 1'b0; tick = 1'b0;
    step_clk();
    rst = 1'b1;
    step_clk();
    gate = 1'b1; attack_rate = 8'd3;
    step_clk();
    run_ticks(39, 2);
    expect_obs("slow_attack_39", 1'b1, 3'd1, 7'd9);
    expect_obs("slow_attack_40", 1'b1, 3'd1, 7'd10);
    expect_obs("slow_non_tick", 1'b1, 3'd1, 7'd10);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) begin
        tick = (k == 1);
        step_clk();
        tick = 1'b0;
      end
      cur_o = {active, state, amplitude}; exp_o = sb_q.pop_front(); tag = tag_q.pop_front();
      total++;
      if (cur_o !== exp_o) begin
        bad++;
        $display("FAIL %s: got act=%0b st=%0d amp=%0d want act=%0b st=%0d amp=%0d",
                 tag, cur_o.act, cur_o.st, cur_o.amp, exp_o.act, exp_o.st, exp_o.amp);
      end
    end
  endtask

  task automatic test_release();
    attack_rate = 8'd0; release_rate = 8'd1;
    run_ticks(40, 1);
    expect_obs("attack_50", 1'b1, 3'd1, 7'd50);
    // falling edge on a tick cycle: tick must be discarded
    expect_obs("release_enter", 1'b1, 3'd4, 7'd50);
    expect_obs("release_99", 1'b1, 3'd4, 7'd1);
    expect_obs("release_idle", 1'b0, 3'd0, 7'd0);
    for (int k = 0; k < 4; k++) begin
      if (k == 1) begin
        gate = 1'b0; tick = 1'b1;
        step_clk();
        tick = 1'b0;
      end else if (k == 2) begin
        run_ticks(99, 1);
      end else if (k == 3) begin
        run_ticks(1, 1);
      end
      cur_o = {active, state, amplitude}; exp_o = sb_q.pop_front(); tag = tag_q.pop_front();
      total++;
      if (cur_o !== exp_o) begin
        bad++;
        $display("FAIL %s: got act=%0b st=%0d amp=%0d want act=%0b st=%0d amp=%0d",
                 tag, cur_o.act, cur_o.st, cur_o.amp, exp_o.act, exp_o.st, exp_o.amp);
      end
    end
  endtask

  task automatic test_retrigger();
    expect_obs("idle_to_attack", 1'b1, 3'd1, 7'd0);
    expect_obs("attack_30", 1'b1, 3'd1, 7'd30);
    expect_obs("release_30", 1'b1, 3'd4, 7'd30);
    expect_obs("retrigger_no_step", 1'b1, 3'd1, 7'd30);
    expect_obs("retrigger_resume", 1'b1, 3'd1, 7'd31);
    for (int k = 0; k < 5; k++) begin
      unique case (k)
        0: begin gate = 1'b1; step_clk(); end
        1: run_ticks(30, 1);
        2: begin gate = 1'b0; step_clk(); end
        3: begin gate = 1'b1; tick = 1'b1; step_clk(); tick = 1'b0; end
        default: run_ticks(1, 1);
      endcase
      cur_o = {active, state, amplitude}; exp_o = sb_q.pop_front(); tag = tag_q.pop_front();
      total++;
      if (cur_o !== exp_o) begin
        bad++;
        $display("FAIL %s: got act=%0b st=%0d amp=%0d want act=%0b st=%0d amp=%0d",
                 tag, cur_o.act, cur_o.st, cur_o.amp, exp_o.act, exp_o.st, exp_o.amp);
      end
    end
  endtask

  task automatic test_sustain_top();
    sustain_level = 7'd127; decay_rate = 8'd0;
    expect_obs("top_decay", 1'b1, 3'd2, 7'd127);
    expect_obs("top_sustain", 1'b1, 3'd3, 7'd127);
    expect_obs("sustain_track", 1'b1, 3'd3, 7'd20);
    expect_obs("sustain_release", 1'b1, 3'd4, 7'd20);
    expect_obs("mid_reset", 1'b0, 3'd0, 7'd0);
    for (int k = 0; k < 5; k++) begin
      unique case (k)
        0: run_ticks(96, 1);
        1: run_ticks(1, 1);
        2: begin sustain_level = 7'd20; step_clk(); end
        3: begin gate = 1'b0; step_clk(); end
        default: begin rst = 1'b0; tick = 1'b1; step_clk(); tick = 1'b0; rst = 1'b1; end
      endcase
      cur_o = {active, state, amplitude}; exp_o = sb_q.pop_front(); tag = tag_q.pop_front();
      total++;
      if (cur_o !== exp_o) begin
        bad++;
        $display("FAIL %s: got act=%0b st=%0d amp=%0d want act=%0b st=%0d amp=%0d",
                 tag, cur_o.act, cur_o.st, cur_o.amp, exp_o.act, exp_o.st, exp_o.amp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_attack_decay();
    test_slow_attack();
    test_release();
    test_retrigger();
    test_sustain_top();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
